// File: rtl/controle_ula_seq_pkg.sv
// Shared types for the sequenced ALU control: select codes, opULA classes,
// funct values and the control FSM states.
package ula_pkg;

   typedef enum logic [3:0] {
      SEL_PASSA = 4'd0,
      SEL_SOMA  = 4'd1,
      SEL_SUB   = 4'd2,
      SEL_MULT  = 4'd3,
      SEL_DIV   = 4'd4,
      SEL_AND   = 4'd5,
      SEL_OR    = 4'd6,
      SEL_INV   = 4'd7,
      SEL_XOR   = 4'd8,
      SEL_SLL   = 4'd9,
      SEL_SRL   = 4'd10
   } sel_e;

   localparam logic [1:0] OP_PASSA = 2'b00;
   localparam logic [1:0] OP_FUNCT = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_SOMA  = 2'b11;

   localparam logic [5:0] F_SOMA = 6'd0;
   localparam logic [5:0] F_SUB  = 6'd1;
   localparam logic [5:0] F_MULT = 6'd2;
   localparam logic [5:0] F_DIV  = 6'd3;
   localparam logic [5:0] F_AND  = 6'd4;
   localparam logic [5:0] F_OR   = 6'd5;
   localparam logic [5:0] F_INV  = 6'd6;
   localparam logic [5:0] F_XOR  = 6'd7;
   localparam logic [5:0] F_SLL  = 6'd8;
   localparam logic [5:0] F_SRL  = 6'd9;

   typedef enum logic {
      OCIOSO  = 1'b0,
      EXECUTA = 1'b1
   } estado_e;

endpackage

// File: rtl/controle_ula_seq_decod_ula_funct.sv
// Combinational decode of {opULA, funct} into ALU select code, hold latency
// and an invalid-funct flag; shared with the hazard unit.
module decod_ula_funct
   import ula_pkg::*;
#(
   parameter int SELEC_W  = 4,
   parameter int LAT_MULT = 4,
   parameter int LAT_DIV  = 8,
   parameter int CNT_W    = 4
) (
   input  logic [1:0]         opULA_i,
   input  logic [5:0]         funct_i,
   output logic [SELEC_W-1:0] selec_o,
   output logic [CNT_W-1:0]   lat_o,
   output logic               invalido_o
);

   sel_e sel_s;

   always_comb begin
      sel_s      = SEL_PASSA;
      invalido_o = 1'b0;
      case (opULA_i)
         OP_PASSA: sel_s = SEL_PASSA;
         OP_SUB:   sel_s = SEL_SUB;
         OP_SOMA:  sel_s = SEL_SOMA;
         default: begin
            case (funct_i)
               F_SOMA:  sel_s = SEL_SOMA;
               F_SUB:   sel_s = SEL_SUB;
               F_MULT:  sel_s = SEL_MULT;
               F_DIV:   sel_s = SEL_DIV;
               F_AND:   sel_s = SEL_AND;
               F_OR:    sel_s = SEL_OR;
               F_INV:   sel_s = SEL_INV;
               F_XOR:   sel_s = SEL_XOR;
               F_SLL:   sel_s = SEL_SLL;
               F_SRL:   sel_s = SEL_SRL;
               default: invalido_o = 1'b1;
            endcase
         end
      endcase
   end

   always_comb begin
      lat_o = CNT_W'(1);
      if (sel_s == SEL_MULT) lat_o = CNT_W'(LAT_MULT);
      if (sel_s == SEL_DIV)  lat_o = CNT_W'(LAT_DIV);
   end

   assign selec_o = SELEC_W'(sel_s);

endmodule

// File: rtl/controle_ula_seq.sv
// Sequenced ALU control: accepts an op via valid/ready, drives a registered
// select code for the op's latency, with busy/done/error pulses and cancel.
module controle_ula_seq
   import ula_pkg::*;
#(
   parameter int INSTR_W  = 32,
   parameter int SELEC_W  = 4,
   parameter int LAT_MULT = 4,
   parameter int LAT_DIV  = 8,
   parameter int CNT_W    = $clog2((LAT_MULT > LAT_DIV) ? LAT_MULT : LAT_DIV) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instrucao,
   input  logic [1:0]         opULA,
   input  logic               valido_in,
   output logic               pronto_out,
   input  logic               descartar,
   output logic [SELEC_W-1:0] selec,
   output logic               selec_valido,
   output logic               ula_ocupada,
   output logic               fim_op,
   output logic               erro_funct
);

   estado_e            estado_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d, lat_q;
   logic [SELEC_W-1:0] selec_q;
   logic               valido_q, ocupada_q, fim_q, erro_q;

   logic [SELEC_W-1:0] dec_selec;
   logic [CNT_W-1:0]   dec_lat;
   logic               dec_invalido;
   logic               aceita;
   logic               unused_bits;

   decod_ula_funct #(
      .SELEC_W  (SELEC_W),
      .LAT_MULT (LAT_MULT),
      .LAT_DIV  (LAT_DIV),
      .CNT_W    (CNT_W)
   ) u_decod (
      .opULA_i    (opULA),
      .funct_i    (instrucao[5:0]),
      .selec_o    (dec_selec),
      .lat_o      (dec_lat),
      .invalido_o (dec_invalido)
   );

   assign unused_bits = ^instrucao[INSTR_W-1:6];

   // Final cycle of an op is also a ready cycle, giving back-to-back issue.
   assign pronto_out = ((estado_q == OCIOSO) | fim_q) & ~descartar;
   assign aceita     = valido_in & pronto_out;
   assign cnt_d      = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q  <= OCIOSO;
         cnt_q     <= '0;
         lat_q     <= CNT_W'(1);
         selec_q   <= '0;
         valido_q  <= 1'b0;
         ocupada_q <= 1'b0;
         fim_q     <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         erro_q <= 1'b0;
         if (aceita) begin
            estado_q  <= EXECUTA;
            cnt_q     <= '0;
            lat_q     <= dec_lat;
            selec_q   <= dec_selec;
            valido_q  <= 1'b1;
            fim_q     <= (dec_lat == CNT_W'(1));
            ocupada_q <= (dec_lat != CNT_W'(1));
            erro_q    <= dec_invalido;
         end else if (estado_q == EXECUTA) begin
            if (descartar || fim_q) begin
               estado_q  <= OCIOSO;
               cnt_q     <= '0;
               valido_q  <= 1'b0;
               fim_q     <= 1'b0;
               ocupada_q <= 1'b0;
            end else begin
               cnt_q     <= cnt_d;
               fim_q     <= (cnt_d == lat_q - CNT_W'(1));
               ocupada_q <= (cnt_d != lat_q - CNT_W'(1));
            end
         end
      end
   end

   assign selec        = selec_q;
   assign selec_valido = valido_q;
   assign ula_ocupada  = ocupada_q;
   assign fim_op       = fim_q;
   assign erro_funct   = erro_q;

endmodule

// File: tb/tb_controle_ula_seq.sv
// Bench for controle_ula_seq: directed steps then random traffic, compared
// each cycle against a remaining-cycles transaction model.
module tb_controle_ula_seq;

   localparam int INSTR_W  = 32;
   localparam int SELEC_W  = 4;
   localparam int LAT_MULT = 4;
   localparam int LAT_DIV  = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [INSTR_W-1:0] instrucao = '0;
   logic [1:0]         opULA = '0;
   logic               valido_in = 1'b0;
   logic               pronto_out;
   logic               descartar = 1'b0;
   logic [SELEC_W-1:0] selec;
   logic               selec_valido, ula_ocupada, fim_op, erro_funct;

   int checks = 0;
   int errors = 0;

   // Reference state: code held, cycles of the op still to be shown, error pulse.
   int m_sel  = 0;
   int m_rem  = 0;
   bit m_erro = 1'b0;

   always #5 clk = ~clk;

   controle_ula_seq #(
      .INSTR_W  (INSTR_W),
      .SELEC_W  (SELEC_W),
      .LAT_MULT (LAT_MULT),
      .LAT_DIV  (LAT_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .instrucao    (instrucao),
      .opULA        (opULA),
      .valido_in    (valido_in),
      .pronto_out   (pronto_out),
      .descartar    (descartar),
      .selec        (selec),
      .selec_valido (selec_valido),
      .ula_ocupada  (ula_ocupada),
      .fim_op       (fim_op),
      .erro_funct   (erro_funct)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                      output int code, output int lat, output bit inval);
      inval = 1'b0;
      case (op)
         2'b00:   code = 0;
         2'b10:   code = 2;
         2'b11:   code = 1;
         default: begin
            if (f <= 6'd9) code = int'(f) + 1;
            else begin
               code  = 0;
               inval = 1'b1;
            end
         end
      endcase
      lat = (op == 2'b01 && code == 3) ? LAT_MULT :
            (op == 2'b01 && code == 4) ? LAT_DIV  : 1;
   endfunction

   task automatic step(input bit r, input bit v, input logic [1:0] op,
                       input logic [5:0] f, input bit d, input string tag);
      logic [31:0] w;
      bit          m_pronto;
      int          code, lat;
      bit          inval;
      w         = $urandom();
      w[5:0]    = f;
      rst       = r;
      valido_in = v;
      opULA     = op;
      instrucao = w;
      descartar = d;
      #1;
      m_pronto = (m_rem <= 1) && !d;
      if (!r) chk({tag, ".pronto"}, {31'b0, pronto_out}, {31'b0, m_pronto});
      @(posedge clk);
      if (r) begin
         m_rem  = 0;
         m_sel  = 0;
         m_erro = 1'b0;
      end else if (v && m_pronto) begin
         ref_decode(op, f, code, lat, inval);
         m_sel  = code;
         m_rem  = lat;
         m_erro = inval;
      end else begin
         m_erro = 1'b0;
         if (m_rem > 0) m_rem = d ? 0 : m_rem - 1;
      end
      #1;
      chk({tag, ".selec"},  32'(selec), 32'(m_sel));
      chk({tag, ".valido"}, {31'b0, selec_valido}, {31'b0, m_rem > 0});
      chk({tag, ".ocupada"}, {31'b0, ula_ocupada}, {31'b0, m_rem > 1});
      chk({tag, ".fim"},    {31'b0, fim_op}, {31'b0, m_rem == 1});
      chk({tag, ".erro"},   {31'b0, erro_funct}, {31'b0, m_erro});
   endtask

   initial begin
      // Reset and a single-cycle add
      step(1, 0, 2'b00, 6'd0, 0, "rst0");
      step(1, 1, 2'b11, 6'd0, 0, "rst1");
      chk("rst.pronto", {31'b0, pronto_out}, 32'd1);
      step(0, 1, 2'b11, 6'd0, 0, "add");
      chk("add.sel1", 32'(selec), 32'd1);
      step(0, 0, 2'b00, 6'd0, 0, "add_idle");

      // Multiply, inputs wiggling while busy
      step(0, 1, 2'b01, 6'd2, 0, "mult");
      chk("mult.sel3", 32'(selec), 32'd3);
      for (int i = 0; i < 4; i++) step(0, 0, 2'b10, 6'd5, 0, "mult_run");

      // Divide followed by add held valid: no bubble
      step(0, 1, 2'b01, 6'd3, 0, "div");
      for (int i = 0; i < 8; i++) step(0, 1, 2'b11, 6'd0, 0, "div_add");
      step(0, 0, 2'b00, 6'd0, 0, "div_add_idle");

      // Extended functs and an unsupported one
      step(0, 1, 2'b01, 6'd7, 0, "xor");
      step(0, 1, 2'b01, 6'd8, 0, "sll");
      step(0, 1, 2'b01, 6'd9, 0, "srl");
      step(0, 1, 2'b01, 6'h3F, 0, "bad");
      chk("bad.erro", {31'b0, erro_funct}, 32'd1);
      step(0, 0, 2'b01, 6'h3F, 0, "bad_after");
      step(0, 1, 2'b00, 6'd4, 0, "passa");
      step(0, 1, 2'b10, 6'd4, 0, "sub");

      // Cancel coincident with final cycle: no new accept
      step(0, 1, 2'b11, 6'd0, 1, "cancel_fim");
      step(0, 0, 2'b00, 6'd0, 0, "cancel_fim_idle");

      // Divide cancelled on cycle 3
      step(0, 1, 2'b01, 6'd3, 0, "div_c");
      step(0, 0, 2'b00, 6'd0, 0, "div_c1");
      step(0, 0, 2'b00, 6'd0, 0, "div_c2");
      step(0, 1, 2'b11, 6'd0, 1, "div_c3");
      chk("div_c.dropped", {31'b0, selec_valido}, 32'd0);
      step(0, 0, 2'b00, 6'd0, 0, "div_c_idle");

      // Reset during a multiply, then a fresh add
      step(0, 1, 2'b01, 6'd2, 0, "mult_r");
      step(0, 0, 2'b00, 6'd0, 0, "mult_r1");
      step(1, 1, 2'b11, 6'd0, 0, "mult_rst");
      step(0, 1, 2'b11, 6'd0, 0, "add_after_rst");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [5:0] f;
         f = ($urandom_range(0, 7) == 0) ? 6'(($urandom_range(0, 1) == 0) ? 6'h3F : 6'd12)
                                         : 6'($urandom_range(0, 9));
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
              2'($urandom_range(0, 3)), f, $urandom_range(0, 99) < 7, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
